// File: rtl/mc_decoder.sv
// Multi-cycle instruction decoder for mypicoMIPS.
// Decodes the 3-bit opcode into PC, ALU, immediate and register-file controls.
// A MUL holds the pipeline for MUL_LAT cycles. An LD waits for switch data
// using a sw_valid/sw_ack handshake. HALT parks the core until reset.
module mc_decoder #(
  parameter int unsigned MUL_LAT = 3,
  localparam int unsigned CW = $clog2(MUL_LAT + 1)
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [2:0] opcode,
  input  logic       flag,
  input  logic       sw_valid,
  output logic       PCincr,
  output logic       PCrelbranch,
  output logic [2:0] ALUfunc,
  output logic       imm,
  output logic       w,
  output logic       sw_ack,
  output logic       stall,
  output logic       halted
);

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpAdd  = 3'd1;
  localparam logic [2:0] OpAddi = 3'd2;
  localparam logic [2:0] OpMul  = 3'd3;
  localparam logic [2:0] OpLd   = 3'd4;
  localparam logic [2:0] OpBeq  = 3'd5;
  localparam logic [2:0] OpBne  = 3'd6;
  localparam logic [2:0] OpHalt = 3'd7;

  typedef enum logic [1:0] {StExec, StMulWait, StLdWait, StHalt} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          taken;

  // State and MUL countdown registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StExec;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mealy next-state and output decode; reset forces every output low at once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    taken       = 1'b0;
    PCincr      = 1'b0;
    PCrelbranch = 1'b0;
    ALUfunc     = 3'd0;
    imm         = 1'b0;
    w           = 1'b0;
    sw_ack      = 1'b0;
    stall       = 1'b0;
    halted      = 1'b0;
    if (n_reset) begin
      unique case (state_q)
        StExec: begin
          ALUfunc = opcode;
          unique case (opcode)
            OpNop: PCincr = 1'b1;
            OpAdd: begin
              w      = 1'b1;
              PCincr = 1'b1;
            end
            OpAddi: begin
              w      = 1'b1;
              imm    = 1'b1;
              PCincr = 1'b1;
            end
            OpMul: begin
              imm = 1'b1;
              if (MUL_LAT == 1) begin
                w      = 1'b1;
                PCincr = 1'b1;
              end else begin
                stall   = 1'b1;
                cnt_d   = CW'(MUL_LAT - 1);
                state_d = StMulWait;
              end
            end
            OpLd: begin
              if (sw_valid) begin
                w      = 1'b1;
                sw_ack = 1'b1;
                PCincr = 1'b1;
              end else begin
                stall   = 1'b1;
                state_d = StLdWait;
              end
            end
            OpBeq, OpBne: begin
              taken       = (opcode == OpBeq) ? flag : ~flag;
              PCrelbranch = taken;
              PCincr      = ~taken;
            end
            OpHalt: begin
              halted  = 1'b1;
              state_d = StHalt;
            end
            default: ;
          endcase
        end
        StMulWait: begin
          ALUfunc = 3'd3;
          imm     = 1'b1;
          if (cnt_q > CW'(1)) begin
            stall = 1'b1;
            cnt_d = cnt_q - CW'(1);
          end else begin
            // Last multiplier cycle: retire and write back.
            w       = 1'b1;
            PCincr  = 1'b1;
            cnt_d   = '0;
            state_d = StExec;
          end
        end
        StLdWait: begin
          ALUfunc = 3'd4;
          if (sw_valid) begin
            w       = 1'b1;
            sw_ack  = 1'b1;
            PCincr  = 1'b1;
            state_d = StExec;
          end else begin
            stall = 1'b1;
          end
        end
        StHalt: halted = 1'b1;
        default: state_d = StExec;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_decoder.sv
// Scoreboard bench for mc_decoder: three instances (MUL_LAT 3, 1, 8) share
// one stimulus stream; a rule-level model predicts every cycle's outputs.
module tb_mc_decoder;

  logic       clk;
  logic       n_reset;
  logic [2:0] opcode;
  logic       flag;
  logic       sw_valid;

  logic [2:0] pi, pr, im, wr, ak, st, hl;
  logic [2:0] alu0, alu1, alu2;
  logic [9:0] act [3];

  // Output vector layout: {PCincr, PCrelbranch, ALUfunc[2:0], imm, w, sw_ack, stall, halted}
  typedef struct packed {
    logic [2:0][9:0] e;
    logic [2:0][9:0] m;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;

  localparam int MIdle = 0;
  localparam int MMul  = 1;
  localparam int MLd   = 2;
  localparam int MHalt = 3;

  int lat_tab [3] = '{3, 1, 8};
  int mode    [3] = '{0, 0, 0};
  int elapsed [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_no = 0;

  mc_decoder #(.MUL_LAT(3)) u_lat3 (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .flag(flag), .sw_valid(sw_valid),
    .PCincr(pi[0]), .PCrelbranch(pr[0]), .ALUfunc(alu0), .imm(im[0]), .w(wr[0]),
    .sw_ack(ak[0]), .stall(st[0]), .halted(hl[0])
  );

  mc_decoder #(.MUL_LAT(1)) u_lat1 (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .flag(flag), .sw_valid(sw_valid),
    .PCincr(pi[1]), .PCrelbranch(pr[1]), .ALUfunc(alu1), .imm(im[1]), .w(wr[1]),
    .sw_ack(ak[1]), .stall(st[1]), .halted(hl[1])
  );

  mc_decoder #(.MUL_LAT(8)) u_lat8 (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .flag(flag), .sw_valid(sw_valid),
    .PCincr(pi[2]), .PCrelbranch(pr[2]), .ALUfunc(alu2), .imm(im[2]), .w(wr[2]),
    .sw_ack(ak[2]), .stall(st[2]), .halted(hl[2])
  );

  assign act[0] = {pi[0], pr[0], alu0, im[0], wr[0], ak[0], st[0], hl[0]};
  assign act[1] = {pi[1], pr[1], alu1, im[1], wr[1], ak[1], st[1], hl[1]};
  assign act[2] = {pi[2], pr[2], alu2, im[2], wr[2], ak[2], st[2], hl[2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the instruction-level rules; returns {mask, expected}.
  function automatic logic [19:0] model(input int lat, input int md, input int el,
                                        input logic [2:0] op, input logic fl,
                                        input logic sv, input logic rst);
    logic pci, prb, imv, wv, akv, stv, hlv, tk;
    logic [2:0] alu;
    logic [9:0] m;
    pci = 0; prb = 0; imv = 0; wv = 0; akv = 0; stv = 0; hlv = 0; tk = 0;
    alu = 3'd0;
    m   = '1;
    if (rst) begin
      case (md)
        MHalt: begin
          hlv = 1;
          m[7:5] = 3'b000;  // ALU function is a don't-care while parked
        end
        MMul: begin
          alu = 3'd3;
          imv = 1;
          if (el + 1 == lat) begin wv = 1; pci = 1; end
          else stv = 1;
        end
        MLd: begin
          alu = 3'd4;
          if (sv) begin wv = 1; akv = 1; pci = 1; end
          else stv = 1;
        end
        default: begin
          alu = op;
          case (op)
            3'd0: pci = 1;
            3'd1: begin wv = 1; pci = 1; end
            3'd2: begin wv = 1; imv = 1; pci = 1; end
            3'd3: begin
              imv = 1;
              if (lat == 1) begin wv = 1; pci = 1; end
              else stv = 1;
            end
            3'd4: begin
              if (sv) begin wv = 1; akv = 1; pci = 1; end
              else stv = 1;
            end
            3'd5, 3'd6: begin
              tk = (op == 3'd5) ? fl : !fl;
              if (tk) prb = 1;
              else pci = 1;
            end
            default: hlv = 1;
          endcase
        end
      endcase
    end
    return {m, {pci, prb, alu, imv, wv, akv, stv, hlv}};
  endfunction

  // One clock cycle of stimulus: drive, predict, then advance the model.
  task automatic cyc(input logic [2:0] op, input logic fl, input logic sv, input logic rst);
    exp_t x;
    logic [19:0] r;
    @(posedge clk);
    #1;
    opcode   = op;
    flag     = fl;
    sw_valid = sv;
    n_reset  = rst;
    for (int i = 0; i < 3; i++) begin
      r = model(lat_tab[i], mode[i], elapsed[i], op, fl, sv, rst);
      x.m[i] = r[19:10];
      x.e[i] = r[9:0];
    end
    sb.push_back(x);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mode[i]    = MIdle;
        elapsed[i] = 0;
      end else begin
        case (mode[i])
          MIdle: begin
            if (op == 3'd3 && lat_tab[i] > 1) begin
              mode[i]    = MMul;
              elapsed[i] = 1;
            end else if (op == 3'd4 && !sv) mode[i] = MLd;
            else if (op == 3'd7) mode[i] = MHalt;
          end
          MMul: begin
            elapsed[i] = elapsed[i] + 1;
            if (elapsed[i] == lat_tab[i]) begin
              mode[i]    = MIdle;
              elapsed[i] = 0;
            end
          end
          MLd: if (sv) mode[i] = MIdle;
          default: ;
        endcase
      end
    end
  endtask

  // Monitor: the decoder presents a response every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      cycle_no++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ((act[i] & mon_x.m[i]) !== (mon_x.e[i] & mon_x.m[i])) begin
          n_fail++;
          $display("FAIL lat%0d cycle %0d: got %b required %b (mask %b)",
                   lat_tab[i], cycle_no, act[i], mon_x.e[i], mon_x.m[i]);
        end
      end
    end
  end

  initial begin
    logic [2:0] op;
    int r;
    n_reset  = 1'b0;
    opcode   = 3'd0;
    flag     = 1'b0;
    sw_valid = 1'b0;

    // Reset, then ADD, ADDI, NOP, then reset again with a live opcode.
    cyc(3'd0, 0, 0, 0);
    cyc(3'd1, 0, 0, 1);
    cyc(3'd2, 0, 0, 1);
    cyc(3'd0, 0, 0, 1);
    cyc(3'd1, 1, 1, 0);

    // MUL held on the opcode bus, then a NOP.
    for (int k = 0; k < 3; k++) cyc(3'd3, 0, 0, 1);
    cyc(3'd0, 0, 0, 1);
    for (int k = 0; k < 8; k++) cyc(3'd0, 0, 0, 1);

    // LD: four cycles without data, then data arrives; then LD with data ready.
    for (int k = 0; k < 4; k++) cyc(3'd4, 0, 0, 1);
    cyc(3'd4, 0, 1, 1);
    cyc(3'd4, 0, 1, 1);
    cyc(3'd0, 0, 0, 1);

    // Branches: all four opcode/flag combinations.
    cyc(3'd5, 0, 0, 1);
    cyc(3'd5, 1, 0, 1);
    cyc(3'd6, 0, 0, 1);
    cyc(3'd6, 1, 0, 1);

    // HALT, 20 cycles of noise, then reset back to normal execution.
    cyc(3'd7, 0, 0, 1);
    for (int k = 0; k < 20; k++)
      cyc(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1);
    cyc(3'd0, 0, 0, 0);
    cyc(3'd1, 0, 0, 1);

    // Mid-MUL reset on the fourth cycle, then a full MUL from scratch.
    for (int k = 0; k < 3; k++) cyc(3'd3, 0, 0, 1);
    cyc(3'd3, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(3'd3, 0, 0, 1);
    for (int k = 0; k < 8; k++) cyc(3'd0, 0, 0, 1);

    // Random instruction stream with rare HALTs and occasional resets.
    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 15));
      op = (r == 15) ? 3'd7 : 3'(r % 7);
      cyc(op, 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) != 0));
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
